// File: rtl/main_mem_burst_if.sv
// Line-burst handshake between the cache (master) and main_mem_burst (slave).
// Carries request, direction, line address, write/read beat data and beat strobes.
interface main_mem_burst_if #(
  parameter int ADDR_BITS = 16
);
  logic                 mem_req;
  logic                 mem_wr;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [63:0]          mem_wdata;
  logic [63:0]          mem_rdata;
  logic                 rvalid;
  logic                 ready;
  logic                 done;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, rvalid, ready, done
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, rvalid, ready, done
  );
endinterface

// File: rtl/main_mem_burst.sv
// Backing store plus burst controller servicing whole-line fills and writebacks.
// Optional MAIN_MEM_STATS_EN adds completed read/write burst counters.
module main_mem_burst #(
  parameter int ADDR_BITS  = 16,
  parameter int LINE_BYTES = 64,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  main_mem_burst_if.slave       bus
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [31:0]           stat_rd_bursts,
  output logic [31:0]           stat_wr_bursts
`endif
);

  localparam int BEATS     = LINE_BYTES / 8;
  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int OFF_BITS  = $clog2(LINE_BYTES);
  localparam int LINE_BITS = ADDR_BITS - OFF_BITS;
  localparam int WORD_BITS = ADDR_BITS - 3;
  localparam int WORDS     = 1 << WORD_BITS;

  localparam logic [3:0]           LAT_INIT  = 4'(LATENCY - 1);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE,
    HOLD
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             lat_q, lat_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic                   wr_q, wr_d;

  logic                   rvalid;
  logic                   ready;
  logic                   done;
  logic                   wr_en;
  logic [WORD_BITS-1:0]   word_idx;
  logic                   unused_addr_bits;

  logic [63:0]            storage [0:WORDS-1];

  // Offset bits inside the line never select anything; bursts always start at beat 0.
  assign unused_addr_bits = ^bus.mem_addr[OFF_BITS-1:0];
  assign word_idx         = {line_q, beat_q};

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    line_d  = line_q;
    wr_d    = wr_q;
    rvalid  = 1'b0;
    ready   = 1'b0;
    done    = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          state_d = WAIT;
          lat_d   = LAT_INIT;
          beat_d  = '0;
          line_d  = bus.mem_addr[ADDR_BITS-1:OFF_BITS];
          wr_d    = bus.mem_wr;
        end
      end
      WAIT: begin
        if (!bus.mem_req) begin
          state_d = IDLE;
        end else if (lat_q == 4'd0) begin
          state_d = wr_q ? WBURST : RBURST;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      // A beat only transfers while the cache still holds the request.
      RBURST: begin
        if (!bus.mem_req) begin
          state_d = IDLE;
        end else begin
          rvalid = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      WBURST: begin
        if (!bus.mem_req) begin
          state_d = IDLE;
        end else begin
          ready  = 1'b1;
          wr_en  = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (!bus.mem_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wr_q    <= wr_d;
    end
  end

  // Storage has no reset; a beat presented in a reset cycle is not committed.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) storage[word_idx] <= bus.mem_wdata;
  end

  assign bus.rvalid    = rvalid;
  assign bus.ready     = ready;
  assign bus.done      = done;
  assign bus.mem_rdata = rvalid ? storage[word_idx] : 64'd0;

`ifdef MAIN_MEM_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [31:0] stat_wr_q, stat_wr_d;

  // Only bursts that reach DONE are counted, so aborts never register.
  always_comb begin
    stat_rd_d = stat_rd_q;
    stat_wr_d = stat_wr_q;
    if (state_q == DONE) begin
      if (wr_q) stat_wr_d = stat_wr_q + 32'd1;
      else      stat_rd_d = stat_rd_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
    end
  end

  assign stat_rd_bursts = stat_rd_q;
  assign stat_wr_bursts = stat_wr_q;
`endif

endmodule

// File: tb/tb_main_mem_burst.sv
// Scoreboard bench for main_mem_burst: directed fills/writebacks, aborts, hold and reset.
// Stat counter checks are compiled in when MAIN_MEM_STATS_EN is defined.
module tb_main_mem_burst;

  typedef struct {
    logic        is_done;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic rst;

  main_mem_burst_if #(.ADDR_BITS(16)) bus ();

`ifdef MAIN_MEM_STATS_EN
  logic [31:0] stat_rd_bursts;
  logic [31:0] stat_wr_bursts;
`endif

  main_mem_burst #(
    .ADDR_BITS (16),
    .LINE_BYTES(64),
    .LATENCY   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus)
`ifdef MAIN_MEM_STATS_EN
    ,
    .stat_rd_bursts(stat_rd_bursts),
    .stat_wr_bursts(stat_wr_bursts)
`endif
  );

  exp_t        exp_q[$];
  logic [63:0] wdata_vec [8];
  logic [63:0] exp_vec   [8];
  int          checks = 0;
  int          errors = 0;
  int          exp_rd = 0;
  int          exp_wr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every beat or done pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t item;
    if (!rst && (bus.rvalid || bus.done)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", {62'd0, bus.rvalid, bus.done}, 64'd0);
      end else begin
        item = exp_q.pop_front();
        checkOutput("output_kind", {63'd0, bus.done}, {63'd0, item.is_done});
        if (!item.is_done) checkOutput("rdata", bus.mem_rdata, item.data);
      end
    end
  end

  task automatic applyStimulus(input logic is_write, input logic [15:0] addr,
                               input int abort_after, input int hold, input string tag);
    int   first_beat, beats, done_at, k, hold_cnt, post, n_exp;
    logic beat_now, finished, dropped;
    first_beat = -1; beats = 0; done_at = -1; k = 0; hold_cnt = 0; post = 0;
    finished = 1'b0; dropped = 1'b0;
    n_exp = (abort_after < 8) ? abort_after : 8;
    if (!is_write) for (int i = 0; i < n_exp; i++) exp_q.push_back('{1'b0, exp_vec[i]});
    if (abort_after >= 8) begin
      exp_q.push_back('{1'b1, 64'd0});
      if (is_write) exp_wr++; else exp_rd++;
    end

    @(posedge clk); #1;
    bus.mem_req   = 1'b1;
    bus.mem_wr    = is_write;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata_vec[0];

    for (int n = 0; n < 80 && !finished; n++) begin
      @(negedge clk);
      beat_now = is_write ? bus.ready : bus.rvalid;
      if (beat_now) begin
        if (first_beat < 0) first_beat = n;
        beats++;
      end
      if (bus.done) done_at = n;
      @(posedge clk); #1;
      // Scramble address/direction after acceptance; the latched copy must win.
      if (n == 0) begin
        bus.mem_addr = ~addr;
        bus.mem_wr   = ~is_write;
      end
      if (is_write && beat_now) begin
        k++;
        if (k < 8) bus.mem_wdata = wdata_vec[k];
        else       bus.mem_wdata = 64'd0;
      end
      if (dropped) begin
        post++;
        if (post >= 2) finished = 1'b1;
      end else if (abort_after < 8 && beats == abort_after) begin
        bus.mem_req = 1'b0;
        dropped = 1'b1;
      end else if (done_at >= 0) begin
        if (hold_cnt == hold) begin
          bus.mem_req = 1'b0;
          finished = 1'b1;
        end else begin
          hold_cnt++;
        end
      end
    end

    checkOutput({tag, "_finished"}, {63'd0, finished}, 64'd1);
    bus.mem_req = 1'b0;
    checkOutput({tag, "_first_beat"}, 64'(first_beat), (abort_after == 0) ? 64'(-1) : 64'd5);
    checkOutput({tag, "_beats"}, 64'(beats), 64'(n_exp));
    checkOutput({tag, "_done_at"}, 64'(done_at), (abort_after >= 8) ? 64'd13 : 64'(-1));
  endtask

  initial begin
    int seen;
    rst           = 1'b1;
    bus.mem_req   = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 64'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_rvalid", {63'd0, bus.rvalid}, 64'd0);
    checkOutput("reset_ready",  {63'd0, bus.ready},  64'd0);
    checkOutput("reset_done",   {63'd0, bus.done},   64'd0);
    checkOutput("reset_rdata",  bus.mem_rdata,       64'd0);
`ifdef MAIN_MEM_STATS_EN
    checkOutput("reset_stat_rd", 64'(stat_rd_bursts), 64'd0);
    checkOutput("reset_stat_wr", 64'(stat_wr_bursts), 64'd0);
`endif

    // Writeback 0x5000 with beats 0x0101.. through 0x0808.., then read it back twice.
    for (int i = 0; i < 8; i++) wdata_vec[i] = {8{8'(i + 1)}};
    applyStimulus(1'b1, 16'h5000, 8, 0, "wb_5000");
    for (int i = 0; i < 8; i++) exp_vec[i] = {8{8'(i + 1)}};
    applyStimulus(1'b0, 16'h5000, 8, 0, "fill_5000");
    applyStimulus(1'b0, 16'h503C, 8, 0, "fill_503c");

    // Top line must not alias onto line 0.
    for (int i = 0; i < 8; i++) wdata_vec[i] = {4{16'hC000 + 16'(i)}};
    applyStimulus(1'b1, 16'h0000, 8, 0, "wb_0000");
    for (int i = 0; i < 8; i++) wdata_vec[i] = 64'hF0F0_0000_0000_0000 + 64'(i);
    applyStimulus(1'b1, 16'hFFC0, 8, 0, "wb_ffc0");
    for (int i = 0; i < 8; i++) exp_vec[i] = 64'hF0F0_0000_0000_0000 + 64'(i);
    applyStimulus(1'b0, 16'hFFC0, 8, 0, "fill_ffc0");
    for (int i = 0; i < 8; i++) exp_vec[i] = {4{16'hC000 + 16'(i)}};
    applyStimulus(1'b0, 16'h0000, 8, 0, "fill_0000");

    // Partial writeback: only the first three beats of B replace A.
    for (int i = 0; i < 8; i++) wdata_vec[i] = {8{8'h10 + 8'(i)}};
    applyStimulus(1'b1, 16'h6000, 8, 0, "wb_6000_a");
    for (int i = 0; i < 8; i++) wdata_vec[i] = 64'hBBBB_0000_0000_0000 + 64'(i);
    applyStimulus(1'b1, 16'h6000, 3, 0, "wb_6000_abort");
    for (int i = 0; i < 8; i++)
      exp_vec[i] = (i < 3) ? 64'hBBBB_0000_0000_0000 + 64'(i) : {8{8'h10 + 8'(i)}};
    applyStimulus(1'b0, 16'h6000, 8, 0, "fill_6000");

    // Request held past done must not restart; the next request is accepted normally.
    for (int i = 0; i < 8; i++) exp_vec[i] = {8{8'(i + 1)}};
    applyStimulus(1'b0, 16'h5000, 8, 5, "fill_hold");
    applyStimulus(1'b0, 16'h5000, 8, 0, "fill_after_hold");
    applyStimulus(1'b0, 16'h5000, 2, 0, "fill_abort");
    applyStimulus(1'b0, 16'h5000, 0, 0, "fill_abort_wait");

    @(negedge clk);
`ifdef MAIN_MEM_STATS_EN
    checkOutput("stat_rd", 64'(stat_rd_bursts), 64'(exp_rd));
    checkOutput("stat_wr", 64'(stat_wr_bursts), 64'(exp_wr));
`endif

    // Reset in the middle of a fill: beats 0-2 are seen, beat 3 is cut off.
    for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, exp_vec[i]});
    @(posedge clk); #1;
    bus.mem_req  = 1'b1;
    bus.mem_wr   = 1'b0;
    bus.mem_addr = 16'h5000;
    seen = 0;
    for (int n = 0; n < 40 && seen < 3; n++) begin
      @(negedge clk);
      if (bus.rvalid) seen++;
    end
    checkOutput("rst_beats_before", 64'(seen), 64'd3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_req = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    @(negedge clk);
    checkOutput("rst_rvalid_low", {63'd0, bus.rvalid}, 64'd0);
    checkOutput("rst_done_low",   {63'd0, bus.done},   64'd0);
    applyStimulus(1'b0, 16'h5000, 8, 0, "fill_after_rst");

    @(negedge clk);
`ifdef MAIN_MEM_STATS_EN
    checkOutput("stat_rd_after_rst", 64'(stat_rd_bursts), 64'(exp_rd));
    checkOutput("stat_wr_after_rst", 64'(stat_wr_bursts), 64'(exp_wr));
`endif
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
